// File: rtl/mandelbrot_pkg.sv
// Shared types and helpers for the mandelbrot pixel writer: widths, the FIFO payload
// and the iteration-to-colour mapping.
package mandelbrot_pkg;

    localparam int unsigned ITERW  = 16;
    localparam int unsigned RCNTW  = 10;
    localparam int unsigned ICNTW  = 10;
    localparam int unsigned H_RES  = 640;
    localparam int unsigned AW     = 19;
    localparam int unsigned COLORW = 12;

    typedef struct packed {
        logic              last;
        logic [AW-1:0]     addr;
        logic [COLORW-1:0] color;
    } pixel_t;

    // Low iteration nibble lands in the most significant colour field; non-diverged is black.
    function automatic logic [COLORW-1:0] iter2color(input logic [ITERW-1:0] iteration,
                                                     input logic             diverged);
        return diverged ? {iteration[3:0], iteration[7:4], iteration[11:8]} : '0;
    endfunction

endpackage

// File: rtl/mandelbrot_pixel_writer_if.sv
// Engine-result and framebuffer-write bundles used by the pixel writer.
interface mandelbrot_result_if;
    import mandelbrot_pkg::*;

    logic [RCNTW-1:0] real_cnt;
    logic [ICNTW-1:0] imag_cnt;
    logic [ITERW-1:0] iteration;
    logic             diverged;
    logic             valid;
    logic             stall;

    modport master (output real_cnt, imag_cnt, iteration, diverged, valid, input stall);
    modport slave  (input real_cnt, imag_cnt, iteration, diverged, valid, output stall);
endinterface

interface mandelbrot_fb_if;
    import mandelbrot_pkg::*;

    logic              fb_req;
    logic [AW-1:0]     fb_addr;
    logic [COLORW-1:0] fb_data;
    logic              fb_ready;

    modport master (output fb_req, fb_addr, fb_data, input fb_ready);
    modport slave  (input fb_req, fb_addr, fb_data, output fb_ready);
endinterface

// File: rtl/mandelbrot_pixel_fifo.sv
// First-word-fall-through FIFO of pixel_t; push and pop may coincide even when full.
module mandelbrot_pixel_fifo
    import mandelbrot_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTRW  = $clog2(DEPTH),
    localparam int unsigned CNTW  = PTRW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  pixel_t          i_data,
    input  logic            i_pop,
    output pixel_t          o_head,
    output logic            o_empty,
    output logic [CNTW-1:0] o_count
);

    pixel_t          r_mem [DEPTH];
    logic [PTRW-1:0] r_wptr;
    logic [PTRW-1:0] r_rptr;
    logic [CNTW-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTRW'(1);
            if (i_pop)  r_rptr <= r_rptr + PTRW'(1);
            r_count <= r_count + CNTW'(i_push) - CNTW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_pop && (r_count == CNTW'(DEPTH))));

endmodule

// File: rtl/mandelbrot_pixel_writer.sv
// Converts engine results to framebuffer writes: address/colour stage, FIFO buffering,
// engine back-pressure and frame busy/done tracking.
module mandelbrot_pixel_writer
    import mandelbrot_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [RCNTW-1:0]       org_x,
    input  logic [ICNTW-1:0]       org_y,
    input  logic [RCNTW-1:0]       real_size,
    input  logic [ICNTW-1:0]       imag_size,
    mandelbrot_result_if.slave     res,
    mandelbrot_fb_if.master        fb,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned CNTW = $clog2(DEPTH) + 1;
    localparam int unsigned OCCW = CNTW + 1;

    logic            r_s1_valid;
    pixel_t          r_s1_pix;
    logic            r_stall;
    logic            r_busy;
    logic            r_done;

    pixel_t          w_s1_next;
    pixel_t          w_head;
    logic            w_empty;
    logic            w_pop;
    logic [CNTW-1:0] w_count;
    logic [CNTW-1:0] w_next_count;
    logic [OCCW-1:0] w_occ;
    logic [OCCW-1:0] w_next_occ;
    logic [31:0]     w_row;
    logic [31:0]     w_col;

    // Stage-1 payload: linear address, colour and end-of-frame marker.
    always_comb begin
        w_row           = 32'(org_y) + 32'(res.imag_cnt);
        w_col           = 32'(org_x) + 32'(res.real_cnt);
        w_s1_next.addr  = AW'(w_row * 32'(H_RES) + w_col);
        w_s1_next.color = iter2color(res.iteration, res.diverged);
        w_s1_next.last  = (res.real_cnt == real_size) && (res.imag_cnt == imag_size);
    end

    always_ff @(posedge clk) begin
        if (res.valid) r_s1_pix <= w_s1_next;
    end

    assign w_pop        = !w_empty && fb.fb_ready;
    assign w_next_count = w_count + CNTW'(r_s1_valid) - CNTW'(w_pop);
    assign w_occ        = OCCW'(w_count) + OCCW'(r_s1_valid);
    assign w_next_occ   = OCCW'(w_next_count) + OCCW'(res.valid);

    // Stall one slot early so a result already in flight in the engine still fits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_stall    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_s1_valid <= res.valid;
            r_stall    <= (w_next_occ >= OCCW'(DEPTH - 1));
            r_done     <= w_pop && w_head.last;
            if (start)
                r_busy <= 1'b1;
            else if (w_pop && w_head.last)
                r_busy <= 1'b0;
        end
    end

    mandelbrot_pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s1_valid),
        .i_data  (r_s1_pix),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign fb.fb_req  = !w_empty;
    assign fb.fb_addr = w_head.addr;
    assign fb.fb_data = w_head.color;
    assign res.stall  = r_stall;
    assign busy       = r_busy;
    assign done       = r_done;

    a_no_drop: assert property (@(posedge clk) disable iff (rst)
        !(res.valid && (w_occ >= OCCW'(DEPTH))));

endmodule

// File: tb/tb_mandelbrot_pixel_writer.sv
// Scoreboard bench for mandelbrot_pixel_writer: directed results queue expected writes,
// a negedge monitor checks every framebuffer handshake and done pulse.
module tb_mandelbrot_pixel_writer;
    import mandelbrot_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [RCNTW-1:0] org_x;
    logic [ICNTW-1:0] org_y;
    logic [RCNTW-1:0] real_size;
    logic [ICNTW-1:0] imag_size;
    logic             busy;
    logic             done;

    mandelbrot_result_if res_if();
    mandelbrot_fb_if     fb_if();

    mandelbrot_pixel_writer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .org_x     (org_x),
        .org_y     (org_y),
        .real_size (real_size),
        .imag_size (imag_size),
        .res       (res_if),
        .fb        (fb_if),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     done_cnt = 0;
    bit     exp_done = 1'b0;
    pixel_t exp_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compare each handshake with the scoreboard head and track done timing.
    always @(negedge clk) begin
        if (rst) begin
            exp_done = 1'b0;
        end else begin
            if (exp_done || done) begin
                check("done_pulse", 32'(done), 32'(exp_done));
                if (exp_done) check("busy_fall_with_done", 32'(busy), 32'd0);
            end
            if (done) done_cnt++;
            exp_done = 1'b0;
            if (fb_if.fb_req && fb_if.fb_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", 32'(fb_if.fb_addr), 32'hFFFF_FFFF);
                end else begin
                    pixel_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(fb_if.fb_addr), 32'(e.addr));
                    check("wr_data", 32'(fb_if.fb_data), 32'(e.color));
                    exp_done = e.last;
                end
            end
        end
    end

    task automatic send(input int rc, input int ic, input int it, input bit dv,
                        input int ea, input int ed, input bit el);
        pixel_t e;
        @(posedge clk); #1;
        res_if.real_cnt  = RCNTW'(rc);
        res_if.imag_cnt  = ICNTW'(ic);
        res_if.iteration = ITERW'(it);
        res_if.diverged  = dv;
        res_if.valid     = 1'b1;
        e.last  = el;
        e.addr  = AW'(ea);
        e.color = COLORW'(ed);
        exp_q.push_back(e);
        @(posedge clk); #1;
        res_if.valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        step(3);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0;
        org_x = '0; org_y = '0;
        real_size = RCNTW'(1023); imag_size = ICNTW'(1023);
        res_if.real_cnt = '0; res_if.imag_cnt = '0; res_if.iteration = '0;
        res_if.diverged = 1'b0; res_if.valid = 1'b0;
        fb_if.fb_ready = 1'b1;
        step(3);
        rst = 1'b0;
        check("rst_stall", 32'(res_if.stall), 32'd0);
        check("rst_fb_req", 32'(fb_if.fb_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Single diverged point: latency two cycles, exactly one write.
        send(3, 2, 'h123, 1'b1, 1283, 'h321, 1'b0);
        check("lat_n1_no_req", 32'(fb_if.fb_req), 32'd0);
        step(1);
        check("lat_n2_req", 32'(fb_if.fb_req), 32'd1);
        check("lat_n2_addr", 32'(fb_if.fb_addr), 32'd1283);
        step(1);
        check("single_handshake", 32'(fb_if.fb_req), 32'd0);
        wait_drain("drain_single");

        // Non-diverged point with offset origin is black.
        org_x = RCNTW'(10); org_y = ICNTW'(5);
        send(0, 0, 'h0AB, 1'b0, 3210, 'h000, 1'b0);
        wait_drain("drain_black");

        // Back-pressure: four results spaced three cycles apart with no drain.
        org_x = '0; org_y = '0;
        fb_if.fb_ready = 1'b0;
        send(1, 1, 'h456, 1'b1, 641, 'h654, 1'b0);
        step(1);
        send(639, 0, 'hABC, 1'b1, 639, 'hCBA, 1'b0);
        check("bp_stall_low_occ2", 32'(res_if.stall), 32'd0);
        step(1);
        send(0, 3, 'h0F0, 1'b1, 1920, 'h0F0, 1'b0);
        check("bp_stall_high_occ3", 32'(res_if.stall), 32'd1);
        step(1);
        send(5, 7, 'h789, 1'b1, 4485, 'h987, 1'b0);
        step(1);
        check("bp_count4", 32'(dut.w_count), 32'd4);
        check("bp_stall_full", 32'(res_if.stall), 32'd1);
        fb_if.fb_ready = 1'b1;
        step(1);
        check("bp_pop1_count", 32'(dut.w_count), 32'd3);
        check("bp_pop1_stall", 32'(res_if.stall), 32'd1);
        step(1);
        check("bp_pop2_count", 32'(dut.w_count), 32'd2);
        check("bp_pop2_stall", 32'(res_if.stall), 32'd0);
        wait_drain("drain_bp");

        // Push and pop in the same cycle with three queued entries.
        fb_if.fb_ready = 1'b0;
        send(10, 0, 'h012, 1'b1, 10, 'h210, 1'b0);
        send(20, 0, 'h345, 1'b1, 20, 'h543, 1'b0);
        send(30, 0, 'h678, 1'b1, 30, 'h876, 1'b0);
        step(2);
        check("sim_count3_pre", 32'(dut.w_count), 32'd3);
        send(40, 0, 'h9AB, 1'b1, 40, 'hBA9, 1'b0);
        fb_if.fb_ready = 1'b1;
        step(1);
        fb_if.fb_ready = 1'b0;
        check("sim_count3_post", 32'(dut.w_count), 32'd3);
        step(2);
        fb_if.fb_ready = 1'b1;
        wait_drain("drain_sim");

        // 2x2 frame: done pulses once after the (1,1) write, busy falls with it.
        real_size = RCNTW'(1); imag_size = ICNTW'(1);
        d0 = done_cnt;
        pulse_start();
        check("busy_rise", 32'(busy), 32'd1);
        send(0, 0, 'h001, 1'b1, 0, 'h100, 1'b0);
        send(1, 0, 'h010, 1'b1, 1, 'h010, 1'b0);
        send(0, 1, 'hFFF, 1'b0, 640, 'h000, 1'b0);
        check("busy_mid_frame", 32'(busy), 32'd1);
        send(1, 1, 'h100, 1'b1, 641, 'h001, 1'b1);
        wait_drain("drain_frame");
        check("frame_done_once", 32'(done_cnt - d0), 32'd1);
        check("frame_busy_low", 32'(busy), 32'd0);

        // Reset with three entries queued flushes everything.
        real_size = RCNTW'(1023); imag_size = ICNTW'(1023);
        pulse_start();
        fb_if.fb_ready = 1'b0;
        send(100, 1, 'h111, 1'b1, 740, 'h111, 1'b0);
        send(101, 1, 'h222, 1'b1, 741, 'h222, 1'b0);
        send(102, 1, 'h333, 1'b1, 742, 'h333, 1'b0);
        step(2);
        check("rstmid_count3", 32'(dut.w_count), 32'd3);
        check("rstmid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_q.delete();
        check("rstmid_fb_req", 32'(fb_if.fb_req), 32'd0);
        check("rstmid_stall", 32'(res_if.stall), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        fb_if.fb_ready = 1'b1;
        step(10);
        check("rstmid_no_stale", 32'(dut.w_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
